// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
//
// Shared CPU definitions for the instruction-fetch PC sequencer. The reset
// and exception-vector constants are also consumed by CP0, so they live here
// rather than inside the sequencer.
//
// Contents:
//   CPU_RESET_PC       - address fetched first after reset
//   CPU_EXC_VECTOR     - common exception entry address
//   PC_STEP            - sequential fetch increment (one 32-bit word)
//   pc_seq_state_e     - sequencer state encoding (RUN / PEND / DRAIN)
//   pick_exc_target()  - exception-vs-eret redirect priority
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam logic [31:0] CPU_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] CPU_EXC_VECTOR = 32'h0040_0004;
    localparam logic [31:0] PC_STEP        = 32'h0000_0004;

    // RUN   : normal sequential / redirected fetch
    // PEND  : branch accepted, its delay slot has not fired yet
    // DRAIN : exception/eret redirect waits for the in-flight fetch
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } pc_seq_state_e;

    // An exception always beats an eret committing in the same cycle.
    function automatic logic [31:0] pick_exc_target(
        input logic        exc_req,
        input logic [31:0] epc,
        input logic [31:0] exc_vector
    );
        return exc_req ? exc_vector : epc;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter of the 5-stage MIPS pipeline and sequences
// instruction fetch. The next PC is chosen between sequential +4, a branch
// redirect resolved in ID, exception entry and eret return. Single
// delay-slot semantics are kept across ID stalls and a variable-latency
// instruction memory: a redirect only takes effect once the delay-slot word
// has actually been handed to IF/ID.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst_n         in   synchronous active-low reset
//   stall_id      in   hazard unit holds IF/ID, fetched word not consumed
//   id_valid      in   ID holds a real instruction
//   is_branch     in   ID instruction redirects the PC
//   branch_pc     in   redirect target from the branch resolver
//   exc_req       in   precise exception raised this cycle
//   eret_req      in   eret committing this cycle
//   epc           in   eret return address
//   imem_req      out  fetch request
//   imem_addr     out  fetch address (== pc)
//   imem_ready    in   instruction word valid for imem_addr this cycle
//   delay_slot_pc out  current pc, fed back to the branch resolver
//   if_valid      out  IF/ID latches the fetched word this cycle
//   if_id_flush   out  IF/ID loads a bubble this cycle
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        id_valid,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] delay_slot_pc,
    output logic        if_valid,
    output logic        if_id_flush
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pc_seq_state_e state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          pend_valid_q, pend_valid_d;
    logic          req_en_q, req_en_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic        exc_any;
    logic [31:0] exc_target;
    logic        fire;
    logic        br_acc;
    logic        flush;

    always_comb begin
        exc_any    = exc_req | eret_req;
        exc_target = pick_exc_target(exc_req, epc, EXC_VECTOR);

        // In DRAIN the returning word belongs to the abandoned stream and is
        // never delivered to IF/ID.
        fire   = req_en_q & imem_ready & ~stall_id & (state_q != DRAIN);

        // Branches are only accepted from RUN; in PEND the delay slot has not
        // left IF yet, so nothing in ID can be a new branch.
        br_acc = id_valid & is_branch & ~stall_id & (state_q == RUN);

        // Flush is qualified by rst_n so a reset cycle never emits a bubble
        // request, and suppressed in DRAIN where IF/ID was already flushed.
        flush  = rst_n & exc_any & (state_q != DRAIN);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req      = req_en_q;
        imem_addr     = pc_q;
        delay_slot_pc = pc_q;
        if_id_flush   = flush;
        // A word fetched in the same cycle as an exception must not enter ID.
        if_valid      = fire & ~flush;
    end

    // ------------------------------------------------------------------
    // Next-PC mux and FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        req_en_d     = 1'b1;

        if (exc_any) begin
            // Exception/eret overrides any pending branch target. If the
            // current fetch has completed we can redirect immediately,
            // otherwise wait in DRAIN for the memory to let go.
            pend_pc_d    = exc_target;
            pend_valid_d = 1'b0;
            if (imem_ready) begin
                pc_d    = exc_target;
                state_d = RUN;
            end else begin
                state_d = DRAIN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (br_acc && fire) begin
                        // Word fired this cycle is the delay slot.
                        pc_d = branch_pc;
                    end else if (br_acc) begin
                        pend_pc_d    = branch_pc;
                        pend_valid_d = 1'b1;
                        state_d      = PEND;
                    end else if (fire) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end

                PEND: begin
                    if (fire && pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                        state_d      = RUN;
                    end
                end

                DRAIN: begin
                    if (imem_ready) begin
                        pc_d    = pend_pc_q;
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d      = RUN;
                    pend_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pend_pc_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            req_en_q     <= req_en_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a behavioural model of the fetch rules (a "current pc", an optional
// pending branch target and an optional pending redirect), updated once per
// clock. Outputs are sampled 1 ns after inputs are applied, well away from
// the rising edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h0040_0004;

    logic        clk;
    logic        rst_n;
    logic        stall_id;
    logic        id_valid;
    logic        is_branch;
    logic [31:0] branch_pc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] delay_slot_pc;
    logic        if_valid;
    logic        if_id_flush;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_br_pending;
    logic [31:0] m_br_target;
    logic        m_redirect_wait;
    logic [31:0] m_redirect_target;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_id     (stall_id),
        .id_valid     (id_valid),
        .is_branch    (is_branch),
        .branch_pc    (branch_pc),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .delay_slot_pc(delay_slot_pc),
        .if_valid     (if_valid),
        .if_id_flush  (if_id_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc              = RST_PC;
        m_req             = 1'b0;
        m_br_pending      = 1'b0;
        m_br_target       = 32'h0;
        m_redirect_wait   = 1'b0;
        m_redirect_target = 32'h0;
    endtask

    // One clock: apply inputs, compare outputs with the model, advance both.
    task automatic cyc(input logic rn, input logic st, input logic idv, input logic isb,
                       input logic [31:0] bpc, input logic ex, input logic er,
                       input logic [31:0] ep, input logic rdy);
        logic        e_fire;
        logic        e_flush;
        logic        redirect;
        logic [31:0] tgt;
        logic        take_branch;

        rst_n      = rn;
        stall_id   = st;
        id_valid   = idv;
        is_branch  = isb;
        branch_pc  = bpc;
        exc_req    = ex;
        eret_req   = er;
        epc        = ep;
        imem_ready = rdy;
        #1;

        redirect = ex | er;
        tgt      = ex ? EXC_PC : ep;
        e_fire   = m_req && rdy && !st && !m_redirect_wait;
        e_flush  = rn && redirect && !m_redirect_wait;

        check1 ("imem_req",      imem_req,      m_req);
        check32("imem_addr",     imem_addr,     m_pc);
        check32("delay_slot_pc", delay_slot_pc, m_pc);
        check1 ("if_valid",      if_valid,      e_fire && !e_flush);
        check1 ("if_id_flush",   if_id_flush,   e_flush);

        @(posedge clk);
        #1;

        if (!rn) begin
            model_reset();
        end else begin
            m_req = 1'b1;
            if (redirect) begin
                m_br_pending      = 1'b0;
                m_redirect_target = tgt;
                if (rdy) begin
                    m_pc            = tgt;
                    m_redirect_wait = 1'b0;
                end else begin
                    m_redirect_wait = 1'b1;
                end
            end else if (m_redirect_wait) begin
                if (rdy) begin
                    m_pc            = m_redirect_target;
                    m_redirect_wait = 1'b0;
                end
            end else if (m_br_pending) begin
                if (e_fire) begin
                    m_pc         = m_br_target;
                    m_br_pending = 1'b0;
                end
            end else begin
                take_branch = idv && isb && !st;
                if (take_branch && e_fire) begin
                    m_pc = bpc;
                end else if (take_branch) begin
                    m_br_pending = 1'b1;
                    m_br_target  = bpc;
                end else if (e_fire) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Convenience wrappers for the directed scenarios.
    task automatic seq(input logic rdy);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Reset, then fetch until pc = 0x0040000C with the word at 0x00400008 in ID.
    task automatic boot_to_40c();
        do_reset();
        repeat (4) seq(1'b1);
        check32("boot_pc", imem_addr, 32'h0040_000C);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall_id   = 1'b0;
        id_valid   = 1'b0;
        is_branch  = 1'b0;
        branch_pc  = 32'h0;
        exc_req    = 1'b0;
        eret_req   = 1'b0;
        epc        = 32'h0;
        imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        check32("reset_pc",     imem_addr,   RST_PC);
        check1 ("reset_req",    imem_req,    1'b0);
        check1 ("reset_valid",  if_valid,    1'b0);
        check1 ("reset_flush",  if_id_flush, 1'b0);

        // Sequential fetch
        seq(1'b1);
        check32("seq_pc0", imem_addr, 32'h0040_0000);
        check1 ("seq_req", imem_req, 1'b1);
        seq(1'b1);
        check32("seq_pc1", imem_addr, 32'h0040_0004);
        seq(1'b1);
        check32("seq_pc2", imem_addr, 32'h0040_0008);
        seq(1'b1);

        // Zero-wait branch: branch at 0x00400008 in ID, delay slot 0x0040000C
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1);
        check32("zw_branch_pc", imem_addr, 32'h0040_0100);

        // Slow delay slot
        boot_to_40c();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 1'b0, 32'h0, 1'b0);
        check32("slow_hold_pc", imem_addr, 32'h0040_000C);
        seq(1'b1);
        check32("slow_branch_pc", imem_addr, 32'h0040_0100);

        // Stall: branch not accepted while stalled
        boot_to_40c();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1);
        check1 ("stall_valid", if_valid, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1);
        check32("stall_hold_pc", imem_addr, 32'h0040_000C);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1);
        check32("stall_branch_pc", imem_addr, 32'h0040_0100);

        // Exception during pending branch
        boot_to_40c();
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
        check32("exc_drain_pc", imem_addr, 32'h0040_000C);
        seq(1'b1);
        check32("exc_vector_pc", imem_addr, 32'h0040_0004);

        // Exception/eret collision: exception wins
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0200, 1'b1);
        check32("collision_pc", imem_addr, EXC_PC);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0200, 1'b1);
        check32("eret_pc", imem_addr, 32'h0040_0200);

        // Reset mid-DRAIN
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check32("rst_drain_pc",  imem_addr, RST_PC);
        check1 ("rst_drain_req", imem_req,  1'b0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 3) == 0),
                r[0],
                ($urandom_range(0, 3) == 0),
                $urandom,
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 19) == 0),
                $urandom,
                ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the 5-stage MIPS pipeline.
- Sits in IF and arbitrates the next-PC source between:
  - sequential +4
  - the ID-stage branch/jump resolver (is_branch/branch_pc)
  - exception entry and eret return.
- Honours MIPS single-delay-slot semantics across ID stalls and a variable-latency instruction memory.
- Feeds the current PC back to the branch resolver as delay_slot_pc.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0040_0004, exception entry address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall_id  in  1  hazard unit holds IF/ID; fetched word must not be consumed.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- is_branch  in  1  ID instruction redirects (taken branch, j/jal, jr/jalr).
- branch_pc  in  32  redirect target from the resolver.
- exc_req  in  1  precise exception raised this cycle.
- eret_req  in  1  eret committing this cycle.
- epc  in  32  eret return address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ready  in  1  instruction word valid for imem_addr this cycle.
- delay_slot_pc  out  32  current pc, to the branch resolver.
- if_valid  out  1  IF/ID latches the fetched word this cycle.
- if_id_flush  out  1  IF/ID must load a bubble.

Behaviour:
- Reset (rst_n low at a clock edge):
  - pc = RESET_PC
  - state = RUN
  - pend_valid = 0, pend_pc = 0
  - req_en = 0 (imem_req = 0)
  - if_valid = 0, if_id_flush = 0
- req_en becomes 1 on the first edge with rst_n high.
- imem_req = req_en. imem_addr = delay_slot_pc = pc.
- fire = imem_req & imem_ready & ~stall_id & (state != DRAIN).
  - if_valid = fire.
  - Memory holds the word and keeps ready while stalled; a stalled word is re-presented, not lost.
- br_acc = id_valid & is_branch & ~stall_id & (state == RUN).
- Next PC is registered and takes effect the cycle after the event.
- States:
  - RUN: normal operation.
  - PEND: a branch is accepted and its delay slot is still being fetched.
  - DRAIN: an exception or eret waits for an in-flight fetch to finish.
- RUN:
  - br_acc & fire: pc <= branch_pc. The word fired this cycle is the delay slot.
  - br_acc & ~fire: pend_pc <= branch_pc, pend_valid <= 1, go to PEND; pc holds.
  - fire only: pc <= pc + 32'h4 (wraps modulo 2^32).
  - Neither: hold.
- PEND:
  - fire: pc <= pend_pc, pend_valid <= 0, go to RUN.
  - Otherwise hold.
  - No new branch can enter ID before the delay slot fires; is_branch is ignored in PEND.
- Exception/eret (exc_req | eret_req) in RUN or PEND:
  - Target = EXC_VECTOR if exc_req, else epc. exc_req wins when both are asserted.
  - Target is latched into pend_pc; pend_valid is cleared of any branch target, so the exception overrides the pending branch.
  - if_id_flush = 1 that cycle; if_valid is forced 0 that cycle.
  - If imem_ready is 1 that cycle: pc <= target, stay or go to RUN.
  - Otherwise: go to DRAIN.
- DRAIN:
  - imem_req stays 1 at the old pc; the word is discarded (if_valid = 0).
  - On imem_ready: pc <= pend_pc, go to RUN.
  - A further exc_req/eret_req in DRAIN overwrites pend_pc with the same priority rule.
- Exception versus stall: exc_req takes effect regardless of stall_id.
- Reset mid-fetch or mid-DRAIN: state is abandoned and the reset values apply next cycle.
- pc[1:0] is driven as loaded; alignment faults are detected elsewhere.

Decomposition:
- Shared CPU package:
  - state encoding PcSeqState {RUN = 2'd0, PEND = 2'd1, DRAIN = 2'd2}
  - RESET_PC and EXC_VECTOR constants, shared with CP0.
- Single flat module, no sub-module; next-PC mux and FSM in one always block.

Test Plan:
- Sequential fetch: reset with rst_n low for 2 cycles, then imem_ready = 1 constantly -> pc 0x00400000, 0x00400004, 0x00400008 on successive cycles; if_valid = 1 from the first request cycle.
- Zero-wait branch: branch at 0x00400008 in ID, branch_pc = 0x00400100, imem_ready = 1 -> delay slot 0x0040000C fires, next pc 0x00400100.
- Slow delay slot: br_acc with imem_ready = 0 for 3 cycles -> state PEND, pc stays 0x0040000C; on ready the slot fires and pc becomes 0x00400100.
- Stall: stall_id = 1 for 2 cycles with imem_ready = 1 -> pc holds, if_valid = 0, branch not accepted; after release behaves as the zero-wait branch case.
- Exception during pending branch: in PEND, exc_req = 1 with imem_ready = 0 -> if_id_flush = 1, state DRAIN; on ready the word is discarded and pc = 0x00400004 (not the branch target).
- Exception/eret collision and reset mid-DRAIN:
  - exc_req and eret_req in the same cycle with epc = 0x00400200 -> pc = EXC_VECTOR.
  - rst_n low mid-DRAIN -> pc = 0x00400000, imem_req = 0.
